// File: rtl/alien_hit_decoder_if.sv
// ---------------------------------------------------------------------------
// alien_hit_decoder_if
// Bundles the frame/collision inputs and the kill/alive outputs of the alien
// hit decoder.
//   master : drives startOfFrame, newLevel, collision, shotX/Y,
//            alienMatrixTLX/Y; observes the decoder outputs.
//   slave  : the decoder side (inputs/outputs mirrored).
// Parameters ROWS/COLS must match the decoder instance.
// ---------------------------------------------------------------------------
interface alien_hit_decoder_if #(
  parameter int ROWS = 4,
  parameter int COLS = 8
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(ROWS * COLS + 1);

  logic                   startOfFrame;
  logic                   newLevel;
  logic                   collision;
  logic [10:0]            shotX;
  logic [10:0]            shotY;
  logic [10:0]            alienMatrixTLX;
  logic [10:0]            alienMatrixTLY;
  logic [ROWS*COLS-1:0]   aliveMask;
  logic                   killPulse;
  logic [ROW_W-1:0]       killRow;
  logic [COL_W-1:0]       killCol;
  logic [10:0]            killMiddleX;
  logic [10:0]            killMiddleY;
  logic [CNT_W-1:0]       remaining;
  logic                   allDead;

  modport master (
    output startOfFrame, newLevel, collision, shotX, shotY,
           alienMatrixTLX, alienMatrixTLY,
    input  aliveMask, killPulse, killRow, killCol, killMiddleX, killMiddleY,
           remaining, allDead
  );

  modport slave (
    input  startOfFrame, newLevel, collision, shotX, shotY,
           alienMatrixTLX, alienMatrixTLY,
    output aliveMask, killPulse, killRow, killCol, killMiddleX, killMiddleY,
           remaining, allDead
  );
endinterface

// File: rtl/alien_hit_decoder.sv
// ---------------------------------------------------------------------------
// alien_hit_decoder
// Maps a shot/alien collision pixel back to an alien matrix cell, clears that
// cell in the alive mask and emits a one-cycle kill strobe with the cell
// indices and its centre pixel. At most one kill is accepted per frame.
//
// Ports:
//   clk     : system clock
//   resetN  : asynchronous active-low reset
//   bus     : alien_hit_decoder_if.slave (frame/collision in, kill/alive out)
//
// Optional feature (macro HIT_MIDDLE_EN):
//   defined   : killMiddleX/Y computed and registered on each kill
//   undefined : killMiddleX/Y tied to 0, no centre adders
//
// Flow: IDLE -(collision)-> CALC -> CHECK -(hit live cell)-> KILL -> LOCKED
//       -(startOfFrame)-> IDLE. A miss in CHECK returns to IDLE so another
//       collision in the same frame is still accepted. newLevel overrides all.
// ---------------------------------------------------------------------------
module alien_hit_decoder #(
  parameter int ROWS      = 4,
  parameter int COLS      = 8,
  parameter int CELL_BITS = 5
) (
  input  logic                  clk,
  input  logic                  resetN,
  alien_hit_decoder_if.slave    bus
);

  localparam int N_CELLS    = ROWS * COLS;
  localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IDX_W      = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
  localparam int CNT_W      = $clog2(N_CELLS + 1);
  localparam int CELL_IDX_W = 11 - CELL_BITS;   // width of |dx| >> CELL_BITS

  localparam logic [CELL_IDX_W-1:0] COLS_C = CELL_IDX_W'(COLS);
  localparam logic [CELL_IDX_W-1:0] ROWS_C = CELL_IDX_W'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_CHECK,
    S_KILL,
    S_LOCKED
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [10:0]          r_shot_x;
  logic [10:0]          r_shot_y;
  logic [10:0]          r_tl_x;
  logic [10:0]          r_tl_y;
  logic [11:0]          r_dx;        // two's complement, bit 11 = sign
  logic [11:0]          r_dy;
  logic [N_CELLS-1:0]   r_alive;
  logic [CNT_W-1:0]     r_remaining;
  logic                 r_kill_pulse;
  logic [ROW_W-1:0]     r_kill_row;
  logic [COL_W-1:0]     r_kill_col;

  logic [CELL_IDX_W-1:0] w_dx_cell;
  logic [CELL_IDX_W-1:0] w_dy_cell;
  logic [COL_W-1:0]      w_col;
  logic [ROW_W-1:0]      w_row;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_hit_alive;
  logic                  w_do_kill;

  // Cell decode from the registered offsets. Sign bits are excluded from the
  // range compare because a negative offset is already rejected on its own.
  assign w_dx_cell   = r_dx[10:CELL_BITS];
  assign w_dy_cell   = r_dy[10:CELL_BITS];
  assign w_col       = r_dx[CELL_BITS +: COL_W];
  assign w_row       = r_dy[CELL_BITS +: ROW_W];
  assign w_idx       = IDX_W'(w_row) * IDX_W'(COLS) + IDX_W'(w_col);
  assign w_in_range  = !r_dx[11] && !r_dy[11] &&
                       (w_dx_cell < COLS_C) && (w_dy_cell < ROWS_C);
  assign w_hit_alive = r_alive[w_idx];

  // newLevel in the KILL cycle discards the hit.
  assign w_do_kill   = (r_state == S_KILL) && !bus.newLevel;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned,
    // which would otherwise infer a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.collision) w_next = S_CALC;
      S_CALC:   w_next = S_CHECK;
      S_CHECK:  w_next = (w_in_range && w_hit_alive) ? S_KILL : S_IDLE;
      S_KILL:   w_next = S_LOCKED;
      S_LOCKED: if (bus.startOfFrame) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (bus.newLevel) w_next = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath: latch, offset, alive mask, kill outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_shot_x     <= '0;
      r_shot_y     <= '0;
      r_tl_x       <= '0;
      r_tl_y       <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_alive      <= '1;
      r_remaining  <= CNT_W'(N_CELLS);
      r_kill_pulse <= 1'b0;
      r_kill_row   <= '0;
      r_kill_col   <= '0;
    end else begin
      r_kill_pulse <= 1'b0;

      // Matrix position is captured with the shot so later TL motion in the
      // same frame does not skew the decode or the centre pixel.
      if (r_state == S_IDLE && bus.collision) begin
        r_shot_x <= bus.shotX;
        r_shot_y <= bus.shotY;
        r_tl_x   <= bus.alienMatrixTLX;
        r_tl_y   <= bus.alienMatrixTLY;
      end

      if (r_state == S_CALC) begin
        r_dx <= {1'b0, r_shot_x} - {1'b0, r_tl_x};
        r_dy <= {1'b0, r_shot_y} - {1'b0, r_tl_y};
      end

      if (bus.newLevel) begin
        r_alive     <= '1;
        r_remaining <= CNT_W'(N_CELLS);
      end else if (w_do_kill) begin
        // CHECK only enters KILL on a set bit, so remaining cannot underflow.
        r_alive[w_idx] <= 1'b0;
        r_remaining    <= r_remaining - CNT_W'(1);
        r_kill_pulse   <= 1'b1;
        r_kill_row     <= w_row;
        r_kill_col     <= w_col;
      end
    end
  end

`ifdef HIT_MIDDLE_EN
  localparam logic [10:0] HALF_CELL = 11'(1 << (CELL_BITS - 1));

  logic [10:0] r_mid_x;
  logic [10:0] r_mid_y;

  // Centre pixel wraps modulo 2^11; no saturation near the screen edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_mid_x <= '0;
      r_mid_y <= '0;
    end else if (w_do_kill) begin
      r_mid_x <= r_tl_x + (11'(w_col) << CELL_BITS) + HALF_CELL;
      r_mid_y <= r_tl_y + (11'(w_row) << CELL_BITS) + HALF_CELL;
    end
  end

  assign bus.killMiddleX = r_mid_x;
  assign bus.killMiddleY = r_mid_y;
`else
  assign bus.killMiddleX = '0;
  assign bus.killMiddleY = '0;
`endif

  assign bus.aliveMask = r_alive;
  assign bus.killPulse = r_kill_pulse;
  assign bus.killRow   = r_kill_row;
  assign bus.killCol   = r_kill_col;
  assign bus.remaining = r_remaining;
  assign bus.allDead   = (r_remaining == '0);

endmodule
